fetch_decode_reg: RTL
=====================

# fetch_decode_reg

Fetch/decode pipeline register for the 16-bit WISC pipeline. It sits between instruction fetch and the decode/execute register and latches the fetched instruction and PC+2. It performs load-use hazard detection against the instruction currently in execute, squashes on branch flush, and runs the HLT drain state machine that freezes fetch and reports when the processor has halted.

## Interface
Parameters:
- HALT_DRAIN_CYCLES, 3: cycles after HLT is latched before `halted` asserts (drains decode/execute/memory/writeback).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_in  in  16  instruction word from instruction memory.
- pc_plus2_in  in  16  PC+2 of instr_in.
- instr_valid_in  in  1  instr_in is a real fetched instruction.
- flush  in  1  taken branch resolved; squash the instruction in this register.
- ex_mem_read  in  1  the instruction in execute is LW.
- ex_dstReg  in  4  destination register of the instruction in execute.
- instr_out  out  16  latched instruction; 16'h0000 when bubble.
- pc_plus2_out  out  16  latched PC+2.
- valid_out  out  1  instr_out is a real instruction.
- stall_out  out  1  freeze PC and this register.
- id_ex_bubble  out  1  decode/execute register must load a bubble this cycle.
- halted  out  1  sticky halt indication.
- stall_cnt  out  16  load-use stall count (see Configuration).
- flush_cnt  out  16  flush count (see Configuration).

## Operation
- Source usage by opcode (instr_out[15:12]) when valid_out=1:
  - 0x0–0x7: [7:4] and [3:0].
  - 0x8 (LW): [7:4].
  - 0x9 (SW): [7:4] and [11:8].
  - 0xA/0xB (LLB/LHB): [11:8].
  - Others: none.
- Load-use hazard: ex_mem_read=1, valid_out=1, and ex_dstReg equals a used source field. ex_dstReg=0 still counts as a hazard.
- Hazard effect: stall_out=1 and id_ex_bubble=1. Register holds; instr_in is ignored.
- Priority: rst > flush > hazard stall > load.
  - flush=1 loads a bubble (instr_out=0, valid_out=0, pc_plus2_out=0) and overrides a hazard. stall_out and id_ex_bubble are 0 in a flush cycle.
- Normal load: instr_out←instr_in, pc_plus2_out←pc_plus2_in, valid_out←instr_valid_in. When instr_valid_in=0, instr_out←0.
- FSM states:
  - RUN: normal operation. Go to DRAIN when a valid HLT (opcode 0xF) is loaded, without flush that cycle.
  - DRAIN: stall_out=1. Register loads bubbles (valid_out=0 from the cycle after HLT leaves). The drain counter decrements each cycle, starting from HALT_DRAIN_CYCLES−1.
    - flush → RUN and the counter clears; the HLT was on the wrong path.
    - Counter reaching 0 → HALTED.
  - HALTED: halted=1, stall_out=1, bubbles only. Exit only via rst.

## Timing
- Reset values: all outputs 0; state RUN; drain counter 0.
- Data latency: 1 cycle, instr_in to instr_out.
- stall_out and id_ex_bubble are combinational from register state plus ex_* inputs. They assert in the same cycle the hazard exists.
- A load-use stall lasts exactly 1 cycle: the next cycle, execute holds the bubble, so ex_mem_read=0.
- halted rises HALT_DRAIN_CYCLES+1 cycles after the HLT was sampled on instr_in (4 for the default).
- rst during DRAIN/HALTED returns to RUN with all outputs 0 on the next edge.

## Configuration
- FD_PERF_CNT_EN:
  - Defined: stall_cnt increments on each cycle with id_ex_bubble=1; flush_cnt increments on each cycle with flush=1. Both saturate at 16'hFFFF and clear on rst.
  - Undefined: both ports remain and are tied to 0; no counter flops are built.

## Structure
- Package fd_pkg:
  - Opcode constants: OP_LW, OP_SW, OP_LLB, OP_LHB, OP_HLT.
  - NOP_INSTR = 16'h0000.
  - FSM state typedef {RUN, DRAIN, HALTED}.
  - Source-usage function returning use_rs, use_rt, use_rd flags.
- Sub-module fd_hazard_detect: combinational load-use compare. Inputs: instr_out, valid_out, ex_mem_read, ex_dstReg. Output: hazard.

## Test plan
- Reset: assert rst with instr_in=16'h1234 and instr_valid_in=1 → all outputs 0. After release, instr_out=16'h1234 one cycle later.
- Load-use: instr_out=16'h0123 (ADD, rs=2, rt=3), ex_mem_read=1, ex_dstReg=3 → stall_out=id_ex_bubble=1, instr_out held for 1 cycle. Repeat with ex_dstReg=5 → no stall.
- Flush over stall: same hazard with flush=1 → no stall; next cycle valid_out=0, instr_out=0.
- Halt: feed 16'hF000 → stall_out=1 next cycle, halted=1 four cycles after sampling and sticky. rst clears it.
- Wrong-path halt: feed 16'hF000, assert flush one cycle later during DRAIN → state RUN, halted stays 0, fetch resumes.
- FD_PERF_CNT_EN defined: 2 load-use stalls and 3 flushes → stall_cnt=2, flush_cnt=3. Undefined: both read 0.

Source files
------------

// File: rtl/fd_pkg.sv
// fd_pkg: opcode constants, FSM state type and source-usage decode for the fetch/decode register.
package fd_pkg;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} fd_state_e;
  typedef struct packed {
    logic use_rs;
    logic use_rt;
    logic use_rd;
  } src_use_t;
  // rs=[7:4], rt=[3:0], rd=[11:8]; SW and LLB/LHB read the rd field as a source
  function automatic src_use_t src_use(input logic [3:0] op);
    src_use_t u;
    u.use_rs = !op[3] || op == OP_LW || op == OP_SW;
    u.use_rt = !op[3];
    u.use_rd = op == OP_SW || op == OP_LLB || op == OP_LHB;
    return u;
  endfunction
endpackage

// File: rtl/fd_hazard_detect.sv
// fd_hazard_detect: combinational load-use compare of the decode instruction against the LW in execute.
module fd_hazard_detect
  import fd_pkg::*;
(
  input  logic [15:0] instr_i,
  input  logic        valid_i,
  input  logic        ex_mem_read_i,
  input  logic [3:0]  ex_dst_i,
  output logic        hazard_o
);
  src_use_t u;
  assign u = src_use(instr_i[15:12]);
  assign hazard_o = ex_mem_read_i && valid_i &&
                    ((u.use_rs && ex_dst_i == instr_i[7:4]) ||
                     (u.use_rt && ex_dst_i == instr_i[3:0]) ||
                     (u.use_rd && ex_dst_i == instr_i[11:8]));
endmodule

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: IF/ID register with load-use stall, flush squash and HLT drain FSM.
// Optional FD_PERF_CNT_EN builds saturating stall/flush counters; otherwise they read 0.
module fetch_decode_reg
  import fd_pkg::*;
#(
  parameter int HALT_DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_plus2_in,
  input  logic        instr_valid_in,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [3:0]  ex_dstReg,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        valid_out,
  output logic        stall_out,
  output logic        id_ex_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  localparam int CW = $clog2(HALT_DRAIN_CYCLES) + 1;
  logic [15:0] instr_q, pc_q;
  logic        valid_q, hazard, load_hlt;
  fd_state_e   state_q;
  logic [CW-1:0] cnt_q;
  fd_hazard_detect u_haz (
    .instr_i      (instr_q),
    .valid_i      (valid_q),
    .ex_mem_read_i(ex_mem_read),
    .ex_dst_i     (ex_dstReg),
    .hazard_o     (hazard)
  );
  assign id_ex_bubble = hazard && !flush;
  assign stall_out    = !flush && (hazard || state_q != RUN);
  assign load_hlt     = state_q == RUN && !flush && !hazard && instr_valid_in && instr_in[15:12] == OP_HLT;
  assign instr_out    = instr_q;
  assign pc_plus2_out = pc_q;
  assign valid_out    = valid_q;
  assign halted       = state_q == HALTED;
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      if (flush || state_q != RUN) begin
        instr_q <= NOP_INSTR;
        pc_q    <= '0;
        valid_q <= 1'b0;
      end else if (!hazard) begin
        instr_q <= instr_valid_in ? instr_in : NOP_INSTR;
        pc_q    <= pc_plus2_in;
        valid_q <= instr_valid_in;
      end
      if (load_hlt) begin
        state_q <= DRAIN;
        cnt_q   <= CW'(HALT_DRAIN_CYCLES - 1);
      end else if (state_q == DRAIN) begin
        if (flush) begin
          state_q <= RUN;
          cnt_q   <= '0;
        end else if (cnt_q == '0) state_q <= HALTED;
        else cnt_q <= cnt_q - CW'(1);
      end
    end
  end
`ifdef FD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_ex_bubble && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
